// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared constants for the multi-cycle MIPS main control unit.
//   - opcode encodings (Instruction[31:26])
//   - FSM state encoding
//   - ALUOp class encodings
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [3:0] ALUOP_ADD   = 4'b0000;
   localparam logic [3:0] ALUOP_SUB   = 4'b0001;
   localparam logic [3:0] ALUOP_FUNCT = 4'b0010;

   // FSM state encoding
   typedef logic [2:0] state_t;
   localparam state_t ST_FETCH  = 3'd0;
   localparam state_t ST_DECODE = 3'd1;
   localparam state_t ST_EXEC   = 3'd2;
   localparam state_t ST_MEM    = 3'd3;
   localparam state_t ST_WB     = 3'd4;

endpackage

// File: rtl/ctrl_fsm_if.sv
// ctrl_fsm_if: bundle between the control unit and the MIPS datapath.
//   master : the control unit (drives control lines, reads OpCode/mem_ready)
//   slave  : the datapath side (drives OpCode/mem_ready, reads control lines)
interface ctrl_fsm_if #(
   parameter int OPW    = 6,
   parameter int ALUOPW = 4
) ();
   logic [OPW-1:0]    OpCode;
   logic              mem_ready;
   logic              RegDst;
   logic              AluSrc;
   logic              MemtoReg;
   logic              RegWrite;
   logic              MemRead;
   logic              MemWrite;
   logic              Branch;
   logic [ALUOPW-1:0] ALUOp;
   logic              pc_en;
   logic              illegal;
   logic [31:0]       instr_cnt;
   logic [31:0]       cycle_cnt;

   modport master (
      input  OpCode, mem_ready,
      output RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp,
      output pc_en, illegal, instr_cnt, cycle_cnt
   );

   modport slave (
      output OpCode, mem_ready,
      input  RegDst, AluSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp,
      input  pc_en, illegal, instr_cnt, cycle_cnt
   );
endinterface

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational static-field decode of the latched opcode.
//   ir_op    in  : latched opcode
//   RegDst, AluSrc, MemtoReg, ALUOp out : static datapath controls
//   legal    out : opcode is one of the supported instructions
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPW    = 6,
   parameter int ALUOPW = 4
) (
   input  logic [OPW-1:0]    ir_op,
   output logic              RegDst,
   output logic              AluSrc,
   output logic              MemtoReg,
   output logic [ALUOPW-1:0] ALUOp,
   output logic              legal
);

   always_comb begin
      RegDst   = 1'b0;
      AluSrc   = 1'b0;
      MemtoReg = 1'b0;
      ALUOp    = ALUOP_ADD;
      legal    = 1'b1;
      case (ir_op)
         OP_RTYPE: begin
            RegDst = 1'b1;
            ALUOp  = ALUOP_FUNCT;
         end
         OP_ADDI:  AluSrc = 1'b1;
         OP_LW: begin
            AluSrc   = 1'b1;
            MemtoReg = 1'b1;
         end
         OP_SW:    AluSrc = 1'b1;
         OP_BEQ:   ALUOp  = ALUOP_SUB;
         default:  legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multi-cycle main control unit for the MIPS datapath.
//   clk   in : rising-edge clock
//   reset in : asynchronous active-high reset
//   bus       : ctrl_fsm_if.master (OpCode/mem_ready in, control strobes, pc_en,
//               illegal, instr_cnt/cycle_cnt out)
// Optional: define CTRL_PERF_CNT_EN to build the cycle/retired-instruction counters;
// otherwise both counter outputs are tied to zero.
module ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int OPW    = 6,
   parameter int ALUOPW = 4
) (
   input  logic      clk,
   input  logic      reset,
   ctrl_fsm_if.master bus
);

   state_t         state_q, state_d;
   logic [OPW-1:0] ir_op_q;
   logic           illegal_q;

   logic              dec_reg_dst, dec_alu_src, dec_mem_to_reg, dec_legal;
   logic [ALUOPW-1:0] dec_alu_op;

   ctrl_decode #(.OPW(OPW), .ALUOPW(ALUOPW)) u_decode (
      .ir_op    (ir_op_q),
      .RegDst   (dec_reg_dst),
      .AluSrc   (dec_alu_src),
      .MemtoReg (dec_mem_to_reg),
      .ALUOp    (dec_alu_op),
      .legal    (dec_legal)
   );

   logic is_lw, is_sw, is_beq;
   assign is_lw  = (ir_op_q == OP_LW);
   assign is_sw  = (ir_op_q == OP_SW);
   assign is_beq = (ir_op_q == OP_BEQ);

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = dec_legal ? ST_EXEC : ST_FETCH;
         ST_EXEC: begin
            if (is_lw || is_sw) state_d = ST_MEM;
            else if (is_beq)    state_d = ST_FETCH;
            else                state_d = ST_WB;
         end
         ST_MEM: begin
            if (bus.mem_ready) state_d = is_lw ? ST_WB : ST_FETCH;
         end
         ST_WB:     state_d = ST_FETCH;
         default:   state_d = ST_FETCH;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         ir_op_q   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_FETCH) ir_op_q <= bus.OpCode;
         if (state_q == ST_DECODE && !dec_legal) illegal_q <= 1'b1;
      end
   end

   // Static fields are forced to 0 in FETCH; ir_op_q still holds the previous instruction.
   logic in_fetch;
   assign in_fetch = (state_q == ST_FETCH);

   assign bus.RegDst   = dec_reg_dst    & ~in_fetch;
   assign bus.AluSrc   = dec_alu_src    & ~in_fetch;
   assign bus.MemtoReg = dec_mem_to_reg & ~in_fetch;
   assign bus.ALUOp    = in_fetch ? '0 : dec_alu_op;

   assign bus.RegWrite = (state_q == ST_WB);
   assign bus.MemRead  = (state_q == ST_MEM) & is_lw;
   assign bus.MemWrite = (state_q == ST_MEM) & is_sw;
   assign bus.Branch   = (state_q == ST_EXEC) & is_beq;
   assign bus.illegal  = illegal_q;

   // Asserted in the final state of each instruction; only the sw term sees mem_ready.
   logic pc_en;
   assign pc_en = (state_q == ST_WB)
                | ((state_q == ST_MEM) & is_sw & bus.mem_ready)
                | ((state_q == ST_EXEC) & is_beq)
                | ((state_q == ST_DECODE) & ~dec_legal);
   assign bus.pc_en = pc_en;

`ifdef CTRL_PERF_CNT_EN
   logic [31:0] instr_cnt_q, cycle_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_cnt_q <= '0;
         cycle_cnt_q <= '0;
      end else begin
         cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (pc_en) instr_cnt_q <= instr_cnt_q + 32'd1;
      end
   end

   assign bus.instr_cnt = instr_cnt_q;
   assign bus.cycle_cnt = cycle_cnt_q;
`else
   assign bus.instr_cnt = '0;
   assign bus.cycle_cnt = '0;
`endif

endmodule

// File: doc/ctrl_fsm.md
# ctrl_fsm

Multi-cycle main control unit directly upstream of the MIPS datapath. Consumes the 6-bit `OpCode` the datapath exposes and drives its control inputs (`RegDst`, `AluSrc`, `MemtoReg`, `RegWrite`, `MemRead`, `MemWrite`, `Branch`, `ALUOp`). It also drives a PC enable, so each instruction occupies 2–5 cycles instead of one. This lets the synchronous data memory insert wait states.

## Interface
Parameters:
- `OPW`, 6, opcode width.
- `ALUOPW`, 4, ALUOp width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `OpCode` in 6: `Instruction[31:26]` from the datapath.
- `mem_ready` in 1: data memory has completed the current access.
- `RegDst`, `AluSrc`, `MemtoReg` out 1 each: static decode of the latched opcode.
- `RegWrite`, `MemRead`, `MemWrite`, `Branch` out 1 each: state-gated strobes.
- `ALUOp` out 4: ALU operation class.
- `pc_en` out 1: PC update enable; high exactly once per instruction.
- `illegal` out 1: sticky flag, set on an unknown opcode.
- `instr_cnt` out 32: retired instruction count.
- `cycle_cnt` out 32: cycle count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB. Reset state is FETCH.
- FETCH → DECODE always. The register `ir_op` captures `OpCode` on this edge.
- DECODE → EXEC for any legal opcode. For an illegal opcode, DECODE → FETCH, `pc_en`=1 in DECODE, and `illegal` is set.
- Opcodes, with the state path for each:
  - R-type 000000: EXEC → WB → FETCH.
  - addi 001000: EXEC → WB → FETCH.
  - lw 100011: EXEC → MEM → WB → FETCH.
  - sw 101011: EXEC → MEM → FETCH.
  - beq 000100: EXEC → FETCH.
- MEM holds while `mem_ready`=0. It leaves on the cycle where `mem_ready`=1.
- Static fields are decoded from `ir_op` and held from DECODE to the end of the instruction. They are 0 in FETCH.
  - `RegDst`=1 for R-type only.
  - `AluSrc`=1 for lw, sw and addi.
  - `MemtoReg`=1 for lw only.
  - `ALUOp`: 4'b0010 for R-type (use funct), 4'b0000 for lw/sw/addi (add), 4'b0001 for beq (sub), 4'b0000 otherwise.
- Strobes (Moore, from state and `ir_op`):
  - `RegWrite`=1 in WB.
  - `MemRead`=1 in MEM for lw, for every cycle including wait cycles.
  - `MemWrite`=1 in MEM for sw, for every cycle including wait cycles.
  - `Branch`=1 in EXEC for beq.
- `pc_en`=1 in the last state of each instruction:
  - WB for R-type, addi and lw.
  - MEM with `mem_ready`=1 for sw.
  - EXEC for beq, coincident with `Branch`, so PC selection uses that cycle's Zero.
  - DECODE for an illegal opcode.
- `pc_en` is the only output that depends combinationally on an input (`mem_ready` in MEM).
- `illegal` is cleared only by `reset`.
- All outputs are 0 at reset.

## Timing
- Cycles per instruction: beq 3, sw 4+w, R-type 4, addi 4, lw 5+w, illegal 2. Here w is the number of `mem_ready`=0 cycles spent in MEM.
- Strobes never overlap. `RegWrite`, `MemWrite` and `pc_en` each assert on at most one edge per instruction, except the MEM strobes, which hold through wait cycles.
- `OpCode` is sampled only on the FETCH→DECODE edge. Changes at other times are ignored.
- Reset mid-instruction forces FETCH immediately. All strobes drop asynchronously, no partial write is completed, and the counters clear.
- `mem_ready` is ignored outside MEM.

## Configuration
- `CTRL_PERF_CNT_EN` defined:
  - `cycle_cnt` increments every cycle out of reset.
  - `instr_cnt` increments on each cycle with `pc_en`=1.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- `CTRL_PERF_CNT_EN` undefined: both counter ports are tied to 0 and no counter flops exist.

## Structure
- Package `ctrl_pkg` holds:
  - opcode constants (`OP_RTYPE`, `OP_ADDI`, `OP_LW`, `OP_SW`, `OP_BEQ`);
  - the state enum;
  - the ALUOp encodings (`ALUOP_ADD`, `ALUOP_SUB`, `ALUOP_FUNCT`).
- Sub-module `ctrl_decode`: combinational mapping from `ir_op` to `RegDst`, `AluSrc`, `MemtoReg`, `ALUOp` and a legal flag. The FSM instantiates it once.

## Test plan
- Reset asserted mid-WB:
  - All outputs go to 0 immediately.
  - The state is FETCH on release.
  - `illegal`=0.
- R-type (`OpCode`=000000):
  - `RegWrite` and `pc_en` are high together only in cycle 4.
  - `RegDst`=1 and `ALUOp`=0010 from cycle 2.
- lw with `mem_ready` low for 2 cycles:
  - `MemRead` is high for 3 cycles.
  - `RegWrite` is high and `MemtoReg`=1 in cycle 7.
  - Total 7 cycles.
- sw with `mem_ready`=1:
  - `MemWrite` is high for one cycle, coincident with `pc_en`, in cycle 4.
  - `RegWrite` never asserts.
- beq:
  - `Branch`, `pc_en` and `ALUOp`=0001 are high together in cycle 3.
  - The next FETCH follows in cycle 4.
- Illegal opcode 111111:
  - `pc_en` asserts in cycle 2 and `illegal` stays set.
  - With `CTRL_PERF_CNT_EN`, after 10 instructions `instr_cnt`=10 and `cycle_cnt` equals the summed CPI.
